univ_shift_reg: RTL and testbench

- Parametrised WIDTH-bit universal register that generalises the single-bit D flip-flop: parallel load, logical/arithmetic shifts, rotates, hold and clear, all under a mode select with clock enable.
- Tracks the number of shifts since the last load, so it doubles as a parallel-to-serial converter in the flip-flop/register library.

---
 rtl/univ_shift_reg_pkg.sv | 23 ++
 rtl/univ_shift_reg_if.sv | 40 ++++
 rtl/univ_shift_reg_dff_bank.sv | 32 +++
 rtl/univ_shift_reg.sv | 114 +++++++++++
 tb/tb_univ_shift_reg.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/univ_shift_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usr_pkg
//  Description : Shared constants for the universal shift register. Holds the
//                3-bit operation-select encoding used by the register and by
//                anything driving its mode input.
//  Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

    localparam int  MODE_W    = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;  // keep q and count
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;  // parallel load, count cleared
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;  // shift left, sin_l into LSB
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;  // shift right, sin_r into MSB
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;  // rotate left
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'd5;  // rotate right
    localparam logic [MODE_W-1:0] MODE_ASR  = 3'd6;  // arithmetic shift right
    localparam logic [MODE_W-1:0] MODE_CLR  = 3'd7;  // back to RESET_VALUE, count cleared

endpackage : usr_pkg
`default_nettype wire

// File: rtl/univ_shift_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : univ_shift_reg_if
//  Description : Control/data bundle of the universal shift register.
//                master : drives en, mode, d, sin_l, sin_r; observes outputs.
//                slave  : the register itself.
//  Ports       : en, mode[2:0], d[WIDTH], sin_l, sin_r  (master -> slave)
//                q[WIDTH], sout_l, sout_r, shift_cnt[CNT_W], drained
//                                                         (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    import usr_pkg::*;

    logic                en;
    logic [MODE_W-1:0]   mode;
    logic [WIDTH-1:0]    d;
    logic                sin_l;
    logic                sin_r;
    logic [WIDTH-1:0]    q;
    logic                sout_l;
    logic                sout_r;
    logic [CNT_W-1:0]    shift_cnt;
    logic                drained;

    modport master (
        output en, mode, d, sin_l, sin_r,
        input  q, sout_l, sout_r, shift_cnt, drained
    );

    modport slave (
        input  en, mode, d, sin_l, sin_r,
        output q, sout_l, sout_r, shift_cnt, drained
    );

endinterface : univ_shift_reg_if
`default_nettype wire

// File: rtl/univ_shift_reg_dff_bank.sv
`default_nettype none
// ============================================================================
//  Module      : dff_bank
//  Description : WIDTH-bit bank of D flip-flops with asynchronous active-low
//                reset to RESET_VALUE; captures d_next on every rising edge.
//  Ports       : clk, reset (active-low, async), d_next[WIDTH] -> q[WIDTH]
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_bank #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] d_next,
    output logic      [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= d_next;
        end
    end

    assign q = r_q;

endmodule : dff_bank
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : univ_shift_reg
//  Description : WIDTH-bit universal register: hold, parallel load, logical
//                and arithmetic shifts, rotates and clear, under a 3-bit mode
//                with clock enable. Counts shifts since the last load
//                (saturating at WIDTH) so it can serve as a P->S converter.
//  Ports       : clk, reset (active-low, async)
//                bus.slave : en, mode, d, sin_l, sin_r in;
//                            q, sout_l, sout_r, shift_cnt, drained out
//  Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = $clog2(WIDTH + 1)
) (
    input  wire logic         clk,
    input  wire logic         reset,
    univ_shift_reg_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(WIDTH);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_shift;
    logic             w_cnt_clr;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_drained;

    // Next-state mux. en=0 and any unlisted encoding fall through to hold.
    always_comb begin
        w_q_next  = w_q;
        w_shift   = 1'b0;
        w_cnt_clr = 1'b0;
        if (bus.en) begin
            case (bus.mode)
                MODE_LOAD: begin
                    w_q_next  = bus.d;
                    w_cnt_clr = 1'b1;
                end
                MODE_SHL: begin
                    w_q_next = {w_q[WIDTH-2:0], bus.sin_l};
                    w_shift  = 1'b1;
                end
                MODE_SHR: begin
                    w_q_next = {bus.sin_r, w_q[WIDTH-1:1]};
                    w_shift  = 1'b1;
                end
                MODE_ROL: begin
                    w_q_next = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
                    w_shift  = 1'b1;
                end
                MODE_ROR: begin
                    w_q_next = {w_q[0], w_q[WIDTH-1:1]};
                    w_shift  = 1'b1;
                end
                MODE_ASR: begin
                    w_q_next = {w_q[WIDTH-1], w_q[WIDTH-1:1]};
                    w_shift  = 1'b1;
                end
                MODE_CLR: begin
                    w_q_next  = RESET_VALUE;
                    w_cnt_clr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Shift counter saturates at WIDTH; the data path keeps shifting past it.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_cnt_clr) begin
            w_cnt_next = '0;
        end else if (w_shift && (r_cnt != c_cnt_max)) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    dff_bank #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_q_bank (
        .clk    (clk),
        .reset  (reset),
        .d_next (w_q_next),
        .q      (w_q)
    );

    // drained is registered from the next count so it rises on the same
    // edge that brings shift_cnt to WIDTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_drained <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_drained <= (w_cnt_next == c_cnt_max);
        end
    end

    assign bus.q         = w_q;
    assign bus.sout_l    = w_q[WIDTH-1];
    assign bus.sout_r    = w_q[0];
    assign bus.shift_cnt = r_cnt;
    assign bus.drained   = r_drained;

endmodule : univ_shift_reg
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_univ_shift_reg
//  Description : Self-checking bench for univ_shift_reg (WIDTH=8,
//                RESET_VALUE=0): directed scenarios followed by random
//                stimulus, compared against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;
    import usr_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    univ_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    univ_shift_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (8'h00),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] m_q;
    int         m_cnt;
    bit         m_drained;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q       = 8'h00;
        m_cnt     = 0;
        m_drained = 1'b0;
    endtask

    task automatic model_step(input bit e, input logic [2:0] m, input logic [7:0] dd,
                              input bit sl, input bit sr);
        bit shifted;
        shifted = 1'b0;
        if (e) begin
            case (m)
                3'd1: begin m_q = dd; m_cnt = 0; end
                3'd2: begin m_q = (m_q << 1) | (sl ? 8'h01 : 8'h00); shifted = 1'b1; end
                3'd3: begin m_q = (m_q >> 1) | (sr ? 8'h80 : 8'h00); shifted = 1'b1; end
                3'd4: begin m_q = (m_q << 1) | (m_q >> 7);           shifted = 1'b1; end
                3'd5: begin m_q = (m_q >> 1) | (m_q << 7);           shifted = 1'b1; end
                3'd6: begin m_q = 8'($signed(m_q) >>> 1);           shifted = 1'b1; end
                3'd7: begin m_q = 8'h00; m_cnt = 0; end
                default: ;
            endcase
            if (shifted && m_cnt < WIDTH) m_cnt++;
        end
        m_drained = (m_cnt == WIDTH);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},       32'(bus.q),         32'(m_q));
        check({tag, ".sout_l"},  32'(bus.sout_l),    32'(m_q >> 7));
        check({tag, ".sout_r"},  32'(bus.sout_r),    32'(m_q & 8'h01));
        check({tag, ".cnt"},     32'(bus.shift_cnt), 32'(m_cnt));
        check({tag, ".drained"}, 32'(bus.drained),   32'(m_drained));
    endtask

    // One clock: drive inputs, take the edge, advance model, check 1ns later.
    task automatic cyc(input string tag, input bit e, input logic [2:0] m,
                       input logic [7:0] dd, input bit sl, input bit sr);
        bus.en    = e;
        bus.mode  = m;
        bus.d     = dd;
        bus.sin_l = sl;
        bus.sin_r = sr;
        @(posedge clk);
        model_step(e, m, dd, sl, sr);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset_pulse(input string tag);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bus.en = 1'b0; bus.mode = MODE_HOLD; bus.d = '0; bus.sin_l = 1'b0; bus.sin_r = 1'b0;
        model_reset();
        #3;
        check_all("por");
        @(negedge clk);
        reset = 1'b1;

        // Async reset mid-cycle while holding A5
        cyc("ld_a5", 1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0);
        check("ld_a5.abs", 32'(bus.q), 32'h000000A5);
        async_reset_pulse("arst");
        check("arst.abs", 32'(bus.q), 32'h0);

        // LOAD then SHL
        cyc("ld81", 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
        cyc("shl1", 1'b1, MODE_SHL,  8'h00, 1'b0, 1'b0);
        check("shl1.abs", 32'(bus.q), 32'h02);
        cyc("shl2", 1'b1, MODE_SHL,  8'h00, 1'b1, 1'b0);
        check("shl2.abs", 32'(bus.q), 32'h05);
        check("shl2.cnt", 32'(bus.shift_cnt), 32'd2);

        // Rotates
        cyc("ld81b", 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
        cyc("rol",   1'b1, MODE_ROL,  8'h00, 1'b0, 1'b0);
        check("rol.abs", 32'(bus.q), 32'h03);
        cyc("ror1",  1'b1, MODE_ROR,  8'h00, 1'b0, 1'b0);
        cyc("ror2",  1'b1, MODE_ROR,  8'h00, 1'b0, 1'b0);
        check("ror2.abs", 32'(bus.q), 32'hC0);

        // ASR vs SHR
        cyc("ld90", 1'b1, MODE_LOAD, 8'h90, 1'b0, 1'b0);
        cyc("asr",  1'b1, MODE_ASR,  8'h00, 1'b0, 1'b0);
        check("asr.abs", 32'(bus.q), 32'hC8);
        cyc("shr",  1'b1, MODE_SHR,  8'h00, 1'b0, 1'b0);
        check("shr.abs", 32'(bus.q), 32'h64);

        // Drain: 8 shifts reach saturation, 9th keeps count, LOAD clears
        cyc("ldff", 1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc("drain", 1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0);
        check("drain.q",   32'(bus.q),         32'h0);
        check("drain.cnt", 32'(bus.shift_cnt), 32'd8);
        check("drain.flag", 32'(bus.drained),  32'd1);
        cyc("drain9", 1'b1, MODE_SHR, 8'h00, 1'b1, 1'b1);
        check("drain9.cnt", 32'(bus.shift_cnt), 32'd8);
        cyc("ld_undrain", 1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0);
        check("undrain.flag", 32'(bus.drained), 32'd0);

        // Enable low overrides mode, then CLR
        cyc("shl_pre", 1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc("en0", 1'b0, MODE_SHL, 8'hFF, 1'b1, 1'b1);
        check("en0.q", 32'(bus.q), 32'h79);
        cyc("clr", 1'b1, MODE_CLR, 8'hFF, 1'b1, 1'b1);
        check("clr.cnt", 32'(bus.shift_cnt), 32'd0);

        // Random stimulus, occasional async reset
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset_pulse("rnd_rst");
            end else begin
                cyc("rnd",
                    ($urandom_range(0, 7) != 0),
                    3'($urandom_range(0, 7)),
                    8'($urandom),
                    1'($urandom),
                    1'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_univ_shift_reg
`default_nettype wire
